// File: rtl/adapter_axi_stream_2_block_fifo.sv
// AXI Stream to ping-pong block FIFO write adapter: acquires one free FIFO half,
// fills it until the block size is reached or tlast arrives, then releases it.
module adapter_axi_stream_2_block_fifo #(
  parameter int DATA_WIDTH      = 24,
  parameter int USER_IN_DATA    = 1,
  parameter int USER_DATA_WIDTH = 4
) (
  input  logic                       i_axi_clk,
  input  logic                       rst,
  input  logic [USER_DATA_WIDTH-1:0] i_axi_user,
  input  logic [DATA_WIDTH-1:0]      i_axi_data,
  input  logic                       i_axi_last,
  input  logic                       i_axi_valid,
  output logic                       o_axi_ready,
  input  logic [1:0]                 i_block_fifo_rdy,
  output logic [1:0]                 o_block_fifo_act,
  input  logic [23:0]                i_block_fifo_size,
  output logic                       o_block_fifo_stb,
  output logic [DATA_WIDTH:0]        o_block_fifo_data,
  output logic [31:0]                o_debug
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READY   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          act_q, act_d;
  logic [23:0]         count_q, count_d;
  logic                stb_q, stb_d;
  logic [DATA_WIDTH:0] data_q, data_d;

  logic        axi_ready;
  logic        accept;
  logic        user_bit;
  logic [24:0] count_inc;
  logic        size_reached;
  logic        unused_user;

  // Only bit 0 of the user field carries information.
  assign unused_user  = ^i_axi_user;
  assign user_bit     = (USER_IN_DATA != 0) ? i_axi_user[0] : 1'b0;

  // 25-bit increment so a size of 0xFFFFFF cannot wrap the end-of-block test.
  assign count_inc    = {1'b0, count_q} + 25'd1;
  assign size_reached = (count_inc >= {1'b0, i_block_fifo_size});

  assign axi_ready    = (state_q == READY) && (count_q < i_block_fifo_size);
  assign accept       = i_axi_valid && axi_ready;

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    count_d = count_q;
    stb_d   = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if ((act_q == 2'b00) && (i_block_fifo_rdy != 2'b00)) begin
          act_d   = i_block_fifo_rdy[0] ? 2'b01 : 2'b10;
          count_d = 24'd0;
          state_d = READY;
        end
      end
      READY: begin
        if (accept) begin
          data_d  = {user_bit, i_axi_data};
          stb_d   = 1'b1;
          count_d = count_inc[23:0];
          if (i_axi_last || size_reached) begin
            state_d = RELEASE;
          end
        end else if (count_q >= i_block_fifo_size) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Drop ownership first; return to IDLE only once act is seen low.
        if (act_q != 2'b00) begin
          act_d = 2'b00;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        act_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_axi_clk) begin
    if (rst) begin
      state_q <= IDLE;
      act_q   <= 2'b00;
      count_q <= 24'd0;
      stb_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      count_q <= count_d;
      stb_q   <= stb_d;
      data_q  <= data_d;
    end
  end

  assign o_axi_ready       = axi_ready;
  assign o_block_fifo_act  = act_q;
  assign o_block_fifo_stb  = stb_q;
  assign o_block_fifo_data = data_q;
  assign o_debug = {count_q[15:0], 6'd0, stb_q, axi_ready, i_block_fifo_rdy,
                    act_q, 2'd0, state_q};

endmodule

// File: tb/tb_adapter_axi_stream_2_block_fifo.sv
// Self-checking bench for adapter_axi_stream_2_block_fifo: a scoreboard queue
// holds expected FIFO words pushed on each handshake and popped on each strobe.
module tb_adapter_axi_stream_2_block_fifo;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    user;
  logic [DW-1:0] data;
  logic          last;
  logic          valid;
  logic          ready;
  logic [1:0]    rdy;
  logic [1:0]    act;
  logic [23:0]   size;
  logic          stb;
  logic [DW:0]   fdata;
  logic [31:0]   dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int stb_cnt  = 0;
  logic [DW:0] sb[$];

  always #5 clk = ~clk;

  adapter_axi_stream_2_block_fifo #(
    .DATA_WIDTH(DW), .USER_IN_DATA(1), .USER_DATA_WIDTH(4)
  ) dut (
    .i_axi_clk(clk), .rst(rst), .i_axi_user(user), .i_axi_data(data),
    .i_axi_last(last), .i_axi_valid(valid), .o_axi_ready(ready),
    .i_block_fifo_rdy(rdy), .o_block_fifo_act(act),
    .i_block_fifo_size(size), .o_block_fifo_stb(stb),
    .o_block_fifo_data(fdata), .o_debug(dbg)
  );

  // Strobe monitor: every written word must match the oldest accepted word.
  always @(negedge clk) begin
    if (stb === 1'b1) begin
      stb_cnt++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL stb_unexpected: got data %h, required no strobe", fdata);
      end else begin
        logic [DW:0] exp;
        exp = sb.pop_front();
        if (fdata !== exp) begin
          n_fail++;
          $display("FAIL stb_data: got %h, required %h", fdata, exp);
        end
      end
      n_checks++;
      if (act === 2'b00) begin
        n_fail++;
        $display("FAIL stb_without_act: act %b, required nonzero", act);
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [3:0] u,
                      input logic l, output int waited);
    waited = 0;
    valid  = 1'b1;
    data   = d;
    user   = u;
    last   = l;
    #1;
    while (ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: ready %b, required 1", ready);
    end else begin
      sb.push_back({u[0], d});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; last = 1'b0; data = '0; user = '0;
    rdy = 2'b00; size = 24'd4;
    repeat (2) @(negedge clk);
    n_checks++;
    if (act !== 2'b00 || stb !== 1'b0 || ready !== 1'b0 || fdata !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: act %b stb %b ready %b data %h, required 00 0 0 0",
               act, stb, ready, fdata);
    end
    n_checks++;
    if (dbg[3:0] !== 4'd0 || dbg[31:16] !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_debug: got %h, required state 0 count 0", dbg);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_block();
    int w;
    size = 24'd4;
    rdy  = 2'b01;
    @(negedge clk);
    n_checks++;
    if (act !== 2'b01 || dbg[3:0] !== 4'd1 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_acquire: act %b state %0d ready %b, required 01 1 1",
               act, dbg[3:0], ready);
    end
    n_checks++;
    if (dbg[5:4] !== 2'b01 || dbg[7:6] !== 2'b01 || dbg[8] !== 1'b1 || dbg[9] !== 1'b0) begin
      n_fail++;
      $display("FAIL full_debug: got %h, required act 01 rdy 01 ready 1 stb 0", dbg);
    end
    rdy = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      send(DW'(i), 4'b0000, i == 4, w);
      n_checks++;
      if (w != 0) begin
        n_fail++;
        $display("FAIL full_throughput: word %0d waited %0d, required 0", i, w);
      end
    end
    valid = 1'b0; last = 1'b0;
    n_checks++;
    if (dbg[3:0] !== 4'd2 || ready !== 1'b0 || act !== 2'b01 || stb !== 1'b1) begin
      n_fail++;
      $display("FAIL full_final: state %0d ready %b act %b stb %b, required 2 0 01 1",
               dbg[3:0], ready, act, stb);
    end
    @(negedge clk);
    n_checks++;
    if (act !== 2'b00 || stb !== 1'b0) begin
      n_fail++;
      $display("FAIL full_release: act %b stb %b, required 00 0", act, stb);
    end
    @(negedge clk);
    n_checks++;
    if (dbg[3:0] !== 4'd0) begin
      n_fail++;
      $display("FAIL full_idle: state %0d, required 0", dbg[3:0]);
    end
  endtask

  task automatic test_early_last();
    int w;
    int c0;
    repeat (2) @(negedge clk);
    size = 24'd8;
    rdy  = 2'b01;
    @(negedge clk);
    rdy = 2'b00;
    c0  = stb_cnt;
    for (int i = 0; i < 3; i++) send(24'h100 + DW'(i), 4'b0000, i == 2, w);
    valid = 1'b0; last = 1'b0;
    rdy   = 2'b10;
    n_checks++;
    if (dbg[3:0] !== 4'd2 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL early_release: state %0d ready %b, required 2 0", dbg[3:0], ready);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (act !== 2'b00) begin
        n_fail++;
        $display("FAIL early_gap: cycle %0d act %b, required 00", k, act);
      end
    end
    @(negedge clk);
    n_checks++;
    if (act !== 2'b10) begin
      n_fail++;
      $display("FAIL early_next_half: act %b, required 10", act);
    end
    n_checks++;
    if (stb_cnt - c0 != 3) begin
      n_fail++;
      $display("FAIL early_count: strobes %0d, required 3", stb_cnt - c0);
    end
    rdy = 2'b00;
    send(24'hABCDEF, 4'b0000, 1'b1, w);
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic test_backpressure();
    logic exp_stb;
    exp_stb = 1'b0;
    repeat (4) @(negedge clk);
    size = 24'd4;
    rdy  = 2'b01;
    @(negedge clk);
    rdy = 2'b00;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk);
      n_checks++;
      if (stb !== exp_stb) begin
        n_fail++;
        $display("FAIL bp_stb: step %0d got %b, required %b", k, stb, exp_stb);
      end
      if (k < 8) begin
        valid = (k % 2 == 0);
        data  = 24'h200 + DW'(k);
        user  = 4'b0000;
        last  = 1'b0;
        #1;
        if (k % 2 == 0) begin
          n_checks++;
          if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready: step %0d got %b, required 1", k, ready);
          end
        end
        exp_stb = valid && ready;
        if (exp_stb) sb.push_back({1'b0, data});
      end
    end
    valid = 1'b0;
    n_checks++;
    if (act !== 2'b00 || dbg[3:0] !== 4'd2 || dbg[31:16] !== 16'd4) begin
      n_fail++;
      $display("FAIL bp_release: act %b state %0d count %0d, required 00 2 4",
               act, dbg[3:0], dbg[31:16]);
    end
  endtask

  task automatic test_both_ready();
    int w;
    repeat (4) @(negedge clk);
    size = 24'd4;
    rdy  = 2'b11;
    @(negedge clk);
    n_checks++;
    if (act !== 2'b01) begin
      n_fail++;
      $display("FAIL both_first: act %b, required 01", act);
    end
    rdy = 2'b10;
    send(24'h300, 4'b0000, 1'b1, w);
    valid = 1'b0; last = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (act !== 2'b10) begin
      n_fail++;
      $display("FAIL both_second: act %b, required 10", act);
    end
    rdy = 2'b00;
    send(24'h301, 4'b0000, 1'b1, w);
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic test_size0();
    int c0;
    repeat (4) @(negedge clk);
    c0    = stb_cnt;
    size  = 24'd0;
    valid = 1'b1;
    data  = 24'h400;
    rdy   = 2'b01;
    @(negedge clk);
    rdy = 2'b00;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (act !== 2'b01 || ready !== 1'b0) begin
        n_fail++;
        $display("FAIL size0_pulse: cycle %0d act %b ready %b, required 01 0", k, act, ready);
      end
      @(negedge clk);
    end
    n_checks++;
    if (act !== 2'b00 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL size0_end: act %b ready %b, required 00 0", act, ready);
    end
    valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stb_cnt != c0) begin
      n_fail++;
      $display("FAIL size0_stb: strobes %0d, required 0", stb_cnt - c0);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    repeat (4) @(negedge clk);
    size = 24'd4;
    rdy  = 2'b01;
    @(negedge clk);
    rdy = 2'b00;
    send(24'h500, 4'b0000, 1'b0, w);
    send(24'h501, 4'b0000, 1'b0, w);
    rst   = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (act !== 2'b00 || stb !== 1'b0 || ready !== 1'b0 || dbg[3:0] !== 4'd0) begin
      n_fail++;
      $display("FAIL rstmid_state: act %b stb %b ready %b state %0d, required 00 0 0 0",
               act, stb, ready, dbg[3:0]);
    end
    rst = 1'b0;
    rdy = 2'b01;
    @(negedge clk);
    n_checks++;
    if (act !== 2'b01 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_resume: act %b ready %b, required 01 1", act, ready);
    end
    rdy = 2'b00;
    send(24'h502, 4'b0000, 1'b1, w);
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic test_user_bit();
    int w;
    repeat (4) @(negedge clk);
    size = 24'd4;
    rdy  = 2'b01;
    @(negedge clk);
    rdy = 2'b00;
    send(24'h600, 4'b0001, 1'b0, w);
    n_checks++;
    if (fdata[DW] !== 1'b1) begin
      n_fail++;
      $display("FAIL user_set: bit %b, required 1", fdata[DW]);
    end
    send(24'h601, 4'b1110, 1'b0, w);
    n_checks++;
    if (fdata[DW] !== 1'b0) begin
      n_fail++;
      $display("FAIL user_clear: bit %b, required 0", fdata[DW]);
    end
    send(24'h602, 4'b0000, 1'b0, w);
    send(24'h603, 4'b1010, 1'b0, w);
    valid = 1'b0;
    n_checks++;
    if (dbg[3:0] !== 4'd2) begin
      n_fail++;
      $display("FAIL user_size_release: state %0d, required 2", dbg[3:0]);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_early_last();
    test_backpressure();
    test_both_ready();
    test_size0();
    test_reset_mid();
    test_user_bit();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d words left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adapter_axi_stream_2_block_fifo.md
# adapter_axi_stream_2_block_fifo

Receives an AXI Stream and writes it into a ping-pong block FIFO write port, one block per activation. Sits at the ingress side of a block-FIFO datapath, the mirror of the block-FIFO-to-AXI-stream adapter. It grabs a ready FIFO half, fills it until the block size is reached or `tlast` arrives, then releases the half so the reader can drain it.

## Interface
- `DATA_WIDTH`, 24: AXI data width in bits.
- `USER_IN_DATA`, 1: when 1, `i_axi_user[0]` is stored in FIFO data bit `DATA_WIDTH`. When 0, that bit is written as 0.
- `USER_DATA_WIDTH`, 4: width of `i_axi_user`.

Ports:
- `i_axi_clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `i_axi_user`  in  USER_DATA_WIDTH  AXI user; only bit 0 is used.
- `i_axi_data`  in  DATA_WIDTH  AXI data.
- `i_axi_last`  in  1  AXI last.
- `i_axi_valid`  in  1  AXI valid.
- `o_axi_ready`  out  1  AXI ready.
- `i_block_fifo_rdy`  in  2  a FIFO half is empty and available.
- `o_block_fifo_act`  out  2  one-hot ownership of a FIFO half.
- `i_block_fifo_size`  in  24  maximum words per block; valid while act is high.
- `o_block_fifo_stb`  out  1  write strobe, one word per cycle.
- `o_block_fifo_data`  out  DATA_WIDTH+1  `{user_bit, data}`.
- `o_debug`  out  32  `[3:0]` state, `[5:4]` act, `[7:6]` rdy, `[8]` ready, `[9]` stb, `[31:16]` count[15:0], other bits 0.

## Operation
- States: IDLE=0, READY=1, RELEASE=2.
- Internal 24-bit counter `r_count`.
- IDLE:
  - Leave IDLE only when `o_block_fifo_act == 0` and `i_block_fifo_rdy != 0`.
  - Select half 0 if `rdy[0]`, otherwise half 1. When both halves are ready, half 0 wins.
  - On selection: set the matching act bit, clear `r_count`, go to READY.
- READY:
  - `o_axi_ready = (state==READY) & (r_count < i_block_fifo_size)`, combinational from registers and the size input.
  - Accept = `i_axi_valid & o_axi_ready`.
  - On accept: register `o_block_fifo_data <= {USER_IN_DATA ? i_axi_user[0] : 0, i_axi_data}`, pulse `o_block_fifo_stb` next cycle, increment `r_count`.
  - Accept with `i_axi_last`, or accept with `r_count+1 >= i_block_fifo_size`: go to RELEASE.
  - `r_count >= i_block_fifo_size` with no accept (including size 0): go to RELEASE.
- RELEASE:
  - Clear all act bits; the final stb is already out.
  - Go to IDLE next cycle.
  - IDLE cannot re-acquire in the same cycle act drops, because it requires act==0 as a registered value.
- Short blocks:
  - A block ended by `tlast` with fewer than size words is released as-is.
  - The FIFO records the word count from the stb pulses.
- Arithmetic: `r_count` and the size comparison are 24-bit unsigned. `r_count+1` is evaluated at 25 bits, so there is no wrap at size 0xFFFFFF.
- Reset:
  - Dominates in any state. Next edge: state=IDLE, act=00, stb=0, data=0, count=0, `o_axi_ready=0`.
  - A block in flight is abandoned without a release cycle.

## Timing
- Acquire: rdy seen in IDLE at edge N; act and state=READY at N+1; `o_axi_ready` may be high from N+1.
- Write latency: accept at edge N gives stb high with data during cycle N+1; one cycle, one strobe per accept.
- Throughput: one word per clock while valid and ready are both high.
- Final accept at N:
  - State=RELEASE and `o_axi_ready=0` at N+1, with the last stb.
  - Act=00 at N+2.
  - IDLE at N+3.
  - Earliest next act at N+4.
- Idle gap between blocks: 3 cycles with ready low.
- `o_axi_ready` never depends combinationally on `i_axi_valid`.
- Stb is never high while act is 00, except the final word in the RELEASE cycle, when act is still set.

## Test plan
- Full block:
  - Stimulus: size=4, rdy=01, valid held high, data 1..4, last on word 4.
  - Response: act=01, four consecutive stb with data 1..4, ready low after 4th accept, act=00 two cycles after 4th accept.
- Early last:
  - Stimulus: size=8, last on word 3.
  - Response: exactly 3 stb, then release; next rdy=10 selects half 1 and act=10.
- Back-pressure on source:
  - Stimulus: size=4, valid toggled 1,0,1,0.
  - Response: stb only the cycle after each valid&ready; count reaches 4 and releases; no duplicated or dropped words.
- Both halves ready:
  - Stimulus: rdy=11.
  - Response: half 0 chosen; after release with rdy=10, half 1 chosen.
- Size 0:
  - Stimulus: size=0.
  - Response: act pulses for 2 cycles, `o_axi_ready` stays 0, no stb.
- Reset mid-block:
  - Stimulus: `rst` asserted after 2 of 4 words.
  - Response: next edge act=00, stb=0, ready=0, state=0; normal acquisition resumes after rst falls.
- User bit:
  - Stimulus: USER_IN_DATA=1 with `i_axi_user[0]=1` on word 1.
  - Response: `o_block_fifo_data[DATA_WIDTH]=1` only on that word.
